// File: rtl/u409_autoconfig.sv
// Zorro II/III AUTOCONFIG responder for the U409 on-board functions at $00E8xxxx.
// Optional Prometheus (Z3) board in the chain is enabled by defining AUTOCONFIG_PRO_EN.
module u409_autoconfig #(
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] MFG_ID      = 16'h0A1C,
    parameter logic [7:0]  PROD_BRIDGE = 8'h01,
    parameter logic [7:0]  PROD_LIDE   = 8'h02,
    parameter logic [7:0]  PROD_PRO    = 8'h03
) (
    input  logic       CLK40,
    input  logic       RESETn,
    input  logic       TSn,
    input  logic       RnW,
    input  logic       AUTOCONFIG_SPACE,
    input  logic [6:0] A,
    input  logic [7:0] D_IN,
    output logic [3:0] D_OUT,
    output logic       D_OE,
    output logic       TAn,
    output logic [7:0] BRIDGE_BASE,
    output logic [6:0] LIDE_BASE,
    output logic [3:0] PRO_BASE,
    output logic [2:0] BOARD_EN,
    output logic       CONFIGURED
);

`ifdef AUTOCONFIG_PRO_EN
    localparam logic [1:0] NBOARDS = 2'd3;
`else
    localparam logic [1:0] NBOARDS = 2'd2;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t     state;
    logic [2:0] wc;
    logic [6:0] a_q;
    logic       rnw_q;
    logic [1:0] bidx;
    logic [3:0] low_latch;
    logic [1:0] board_en_lo;
    logic       z3_board;
    logic       unused_din;

    assign z3_board   = (bidx == 2'd2);
    assign unused_din = ^D_IN[3:0];

`ifdef AUTOCONFIG_PRO_EN
    logic [3:0] pro_base;
    logic       pro_en;
    assign PRO_BASE = pro_base;
    assign BOARD_EN = {pro_en, board_en_lo};
`else
    assign PRO_BASE = 4'h0;
    assign BOARD_EN = {1'b0, board_en_lo};
`endif

    // Nibble presented on D[31:28]; only $00/$02/$40/$42 are served un-inverted.
    function automatic logic [3:0] rom_nibble(input logic [6:0] off, input logic [1:0] board);
        logic [7:0] type_code;
        logic [7:0] prod;
        logic [3:0] flags_hi;
        logic [3:0] nib;
        case (board)
            2'd0: begin
                type_code = 8'hC1;
                prod      = PROD_BRIDGE;
                flags_hi  = 4'h0;
            end
            2'd1: begin
                type_code = 8'hD2;
                prod      = PROD_LIDE;
                flags_hi  = 4'h0;
            end
            default: begin
                type_code = 8'h84;
                prod      = PROD_PRO;
                flags_hi  = 4'h3;
            end
        endcase
        case (off)
            7'h00:   nib = type_code[7:4];
            7'h01:   nib = type_code[3:0];
            7'h02:   nib = prod[7:4];
            7'h03:   nib = prod[3:0];
            7'h04:   nib = flags_hi;
            7'h08:   nib = MFG_ID[15:12];
            7'h09:   nib = MFG_ID[11:8];
            7'h0A:   nib = MFG_ID[7:4];
            7'h0B:   nib = MFG_ID[3:0];
            default: nib = 4'h0;
        endcase
        if (off == 7'h00 || off == 7'h01 || off == 7'h20 || off == 7'h21) begin
            return nib;
        end
        return ~nib;
    endfunction

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            state       <= ST_IDLE;
            wc          <= 3'd0;
            a_q         <= 7'd0;
            rnw_q       <= 1'b1;
            bidx        <= 2'd0;
            low_latch   <= 4'h0;
            board_en_lo <= 2'b00;
            TAn         <= 1'b1;
            D_OE        <= 1'b0;
            D_OUT       <= 4'h0;
            BRIDGE_BASE <= 8'h00;
            LIDE_BASE   <= 7'h00;
            CONFIGURED  <= 1'b0;
`ifdef AUTOCONFIG_PRO_EN
            pro_base    <= 4'h0;
            pro_en      <= 1'b0;
`endif
        end else begin
            CONFIGURED <= (bidx == NBOARDS);
            case (state)
                ST_IDLE: begin
                    TAn   <= 1'b1;
                    D_OE  <= 1'b0;
                    D_OUT <= 4'h0;
                    if (!TSn && AUTOCONFIG_SPACE && (bidx < NBOARDS)) begin
                        state <= ST_WAIT;
                        a_q   <= A;
                        rnw_q <= RnW;
                        wc    <= 3'(WAIT_STATES - 1);
                        D_OE  <= RnW;
                        D_OUT <= RnW ? rom_nibble(A, bidx) : 4'h0;
                    end
                end
                ST_WAIT: begin
                    if (wc == 3'd0) begin
                        state <= ST_ACK;
                        TAn   <= 1'b0;
                        // Writes commit on the same edge that asserts TAn.
                        if (!rnw_q) begin
                            case (a_q)
                                7'h25: begin
                                    if (!z3_board) low_latch <= D_IN[7:4];
                                end
                                7'h24: begin
                                    if (bidx == 2'd0) begin
                                        BRIDGE_BASE    <= {D_IN[7:4], low_latch};
                                        board_en_lo[0] <= 1'b1;
                                        bidx           <= bidx + 2'd1;
                                    end else if (bidx == 2'd1) begin
                                        LIDE_BASE      <= {D_IN[7:4], low_latch[3:1]};
                                        board_en_lo[1] <= 1'b1;
                                        bidx           <= bidx + 2'd1;
                                    end
                                end
                                7'h22: begin
`ifdef AUTOCONFIG_PRO_EN
                                    if (z3_board) begin
                                        pro_base <= D_IN[7:4];
                                        pro_en   <= 1'b1;
                                        bidx     <= bidx + 2'd1;
                                    end
`endif
                                end
                                7'h26: bidx <= bidx + 2'd1;
                                default: ;
                            endcase
                        end
                    end else begin
                        wc <= wc - 3'd1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    TAn   <= 1'b1;
                    D_OE  <= 1'b0;
                    D_OUT <= 4'h0;
                end
                default: begin
                    state <= ST_IDLE;
                    TAn   <= 1'b1;
                    D_OE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_u409_autoconfig.sv
// Randomised scoreboard bench for u409_autoconfig; adapts to AUTOCONFIG_PRO_EN.
module tb_u409_autoconfig;

    localparam int WS = 2;
`ifdef AUTOCONFIG_PRO_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic       CLK40 = 1'b0;
    logic       RESETn = 1'b0;
    logic       TSn = 1'b1;
    logic       RnW = 1'b1;
    logic       AUTOCONFIG_SPACE = 1'b0;
    logic [6:0] A = 7'd0;
    logic [7:0] D_IN = 8'd0;
    logic [3:0] D_OUT;
    logic       D_OE;
    logic       TAn;
    logic [7:0] BRIDGE_BASE;
    logic [6:0] LIDE_BASE;
    logic [3:0] PRO_BASE;
    logic [2:0] BOARD_EN;
    logic       CONFIGURED;

    u409_autoconfig #(.WAIT_STATES(WS)) dut (
        .CLK40(CLK40), .RESETn(RESETn), .TSn(TSn), .RnW(RnW),
        .AUTOCONFIG_SPACE(AUTOCONFIG_SPACE), .A(A), .D_IN(D_IN),
        .D_OUT(D_OUT), .D_OE(D_OE), .TAn(TAn),
        .BRIDGE_BASE(BRIDGE_BASE), .LIDE_BASE(LIDE_BASE), .PRO_BASE(PRO_BASE),
        .BOARD_EN(BOARD_EN), .CONFIGURED(CONFIGURED)
    );

    always #5 CLK40 = ~CLK40;

    typedef struct {
        bit         rd;
        logic [3:0] nib;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   num_checks = 0;
    int   num_fail = 0;
    int   neg_cycle = 0;
    int   stray = 0;
    int   oe_run = 0;

    logic [7:0]  type_tbl [3] = '{8'hC1, 8'hD2, 8'h84};
    logic [7:0]  prod_tbl [3] = '{8'h01, 8'h02, 8'h03};
    logic [7:0]  flag_tbl [3] = '{8'h00, 8'h00, 8'h30};
    logic [15:0] mfg = 16'h0A1C;

    int         m_bidx;
    logic [7:0] m_bridge;
    logic [6:0] m_lide;
    logic [3:0] m_pro;
    logic [3:0] m_low;
    logic [2:0] m_en;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        num_checks++;
        if (got !== want) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Header bytes laid out as the ROM's nibble stream; nibble n lives at offset 2n.
    function automatic logic [3:0] exp_nibble(input int board, input logic [7:0] off);
        logic [7:0] hdr [8];
        logic [7:0] b;
        logic [3:0] lg;
        int n;
        hdr[0] = type_tbl[board];
        hdr[1] = prod_tbl[board];
        hdr[2] = flag_tbl[board];
        hdr[3] = 8'h00;
        hdr[4] = mfg[15:8];
        hdr[5] = mfg[7:0];
        hdr[6] = 8'h00;
        hdr[7] = 8'h00;
        n = int'(off) >> 1;
        if (n < 16) begin
            b  = hdr[n / 2];
            lg = (n % 2 == 0) ? b[7:4] : b[3:0];
        end else begin
            lg = 4'h0;
        end
        if (off == 8'h00 || off == 8'h02 || off == 8'h40 || off == 8'h42) return lg;
        return ~lg;
    endfunction

    task automatic model_reset();
        m_bidx   = 0;
        m_bridge = 8'h00;
        m_lide   = 7'h00;
        m_pro    = 4'h0;
        m_low    = 4'h0;
        m_en     = 3'b000;
    endtask

    task automatic model_write(input logic [7:0] off, input logic [7:0] data);
        bit         z3 = (m_bidx == 2);
        logic [7:0] base;
        base = {data[7:4], m_low};
        case (off)
            8'h4A: if (!z3) m_low = data[7:4];
            8'h48: if (!z3) begin
                if (m_bidx == 0) m_bridge = base;
                else m_lide = base[7:1];
                m_en[m_bidx] = 1'b1;
                m_bidx++;
            end
            8'h44: if (z3) begin
                m_pro   = data[7:4];
                m_en[2] = 1'b1;
                m_bidx++;
            end
            8'h4C: m_bidx++;
            default: ;
        endcase
    endtask

    // Monitor: consumes expectations whenever the DUT drives data or acknowledges.
    always @(negedge CLK40) begin
        exp_t e;
        neg_cycle++;
        if (D_OE === 1'b1) oe_run++;
        else oe_run = 0;
        if (D_OE === 1'b1) begin
            if (sb.size() == 0) begin
                stray++;
                check("stray_oe", 32'(D_OE), 32'd0);
            end else begin
                check("oe_only_on_read", 32'(sb[0].rd), 32'd1);
                if (sb[0].rd) check("read_nibble", 32'(D_OUT), 32'(sb[0].nib));
            end
        end
        if (TAn === 1'b0) begin
            if (sb.size() == 0) begin
                stray++;
                check("stray_ack", 32'(TAn), 32'd1);
            end else begin
                e = sb.pop_front();
                check("ack_latency", 32'(neg_cycle), 32'(e.cyc));
                if (e.rd) begin
                    check("oe_at_ack", 32'(D_OE), 32'd1);
                    check("oe_length", 32'(oe_run), 32'(WS + 1));
                end else begin
                    check("no_oe_on_write", 32'(D_OE), 32'd0);
                end
            end
        end
    end

    task automatic checkOutput();
        check("tan_idle", 32'(TAn), 32'd1);
        check("doe_idle", 32'(D_OE), 32'd0);
        check("bridge_base", 32'(BRIDGE_BASE), 32'(m_bridge));
        check("lide_base", 32'(LIDE_BASE), 32'(m_lide));
        check("pro_base", 32'(PRO_BASE), 32'(m_pro));
        check("board_en", 32'(BOARD_EN), 32'(m_en));
        check("configured", 32'(CONFIGURED), 32'(m_bidx == NB));
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(posedge CLK40);
        end
        if (sb.size() != 0) begin
            check("ack_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input bit rd, input logic [7:0] off, input logic [7:0] data);
        exp_t e;
        @(posedge CLK40); #1;
        e.rd  = rd;
        e.nib = rd ? exp_nibble(m_bidx, off) : 4'h0;
        e.cyc = neg_cycle + 2 + WS;
        sb.push_back(e);
        if (!rd) model_write(off, data);
        TSn = 1'b0; RnW = rd; A = off[7:1]; D_IN = data; AUTOCONFIG_SPACE = 1'b1;
        @(posedge CLK40); #1;
        TSn = 1'b1; AUTOCONFIG_SPACE = 1'b0;
        waitDrain();
        @(negedge CLK40);
        checkOutput();
    endtask

    task automatic probeEmpty();
        int s0;
        @(posedge CLK40); #1;
        s0 = stray;
        TSn = 1'b0; RnW = 1'b1; A = 7'd0; AUTOCONFIG_SPACE = 1'b1;
        @(posedge CLK40); #1;
        TSn = 1'b1; AUTOCONFIG_SPACE = 1'b0;
        repeat (12) @(posedge CLK40);
        check("no_response_when_done", 32'(stray - s0), 32'd0);
    endtask

    task automatic resetDut();
        @(posedge CLK40); #1;
        RESETn = 1'b0;
        @(posedge CLK40); #1;
        RESETn = 1'b1;
        sb.delete();
        model_reset();
        @(negedge CLK40);
        checkOutput();
        check("reset_dout", 32'(D_OUT), 32'd0);
    endtask

    task automatic resetDuringWait();
        exp_t e;
        @(posedge CLK40); #1;
        e.rd  = 1'b1;
        e.nib = exp_nibble(m_bidx, 8'h00);
        e.cyc = neg_cycle + 2 + WS;
        sb.push_back(e);
        TSn = 1'b0; RnW = 1'b1; A = 7'd0; AUTOCONFIG_SPACE = 1'b1;
        @(posedge CLK40); #1;
        TSn = 1'b1; AUTOCONFIG_SPACE = 1'b0;
        RESETn = 1'b0;
        @(posedge CLK40); #1;
        RESETn = 1'b1;
        sb.delete();
        model_reset();
        @(negedge CLK40);
        checkOutput();
        check("reset_wait_dout", 32'(D_OUT), 32'd0);
    endtask

    task automatic randomChain();
        logic [7:0] off;
        int op;
        for (int i = 0; i < 40 && m_bidx < NB; i++) begin
            op  = $urandom_range(0, 9);
            off = {7'($urandom_range(0, 127)), 1'b0};
            case (op)
                0, 1, 2, 3: applyStimulus(1'b1, off, 8'h00);
                4:          applyStimulus(1'b0, off, 8'($urandom));
                5, 6:       applyStimulus(1'b0, 8'h4A, 8'($urandom));
                7:          applyStimulus(1'b0, 8'h48, 8'($urandom));
                8:          applyStimulus(1'b0, 8'h44, 8'($urandom));
                default:    applyStimulus(1'b0, 8'h4C, 8'($urandom));
            endcase
        end
        for (int i = 0; i < NB && m_bidx < NB; i++) applyStimulus(1'b0, 8'h4C, 8'h00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] off;
        model_reset();
        repeat (3) @(posedge CLK40);
        #1 RESETn = 1'b1;
        @(negedge CLK40);
        checkOutput();
        check("reset_dout", 32'(D_OUT), 32'd0);

        applyStimulus(1'b1, 8'h00, 8'h00);
        applyStimulus(1'b1, 8'h02, 8'h00);
        applyStimulus(1'b1, 8'h04, 8'h00);
        applyStimulus(1'b1, 8'h06, 8'h00);
        applyStimulus(1'b1, 8'h10, 8'h00);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, {7'($urandom_range(0, 127)), 1'b0}, 8'h00);
        for (int i = 0; i < 6; i++) begin
            off = {7'($urandom_range(0, 127)), 1'b0};
            if (off inside {8'h44, 8'h48, 8'h4A, 8'h4C}) off = 8'h50;
            applyStimulus(1'b0, off, 8'($urandom));
        end

        applyStimulus(1'b0, 8'h4A, 8'h20);
        applyStimulus(1'b0, 8'h48, 8'hE9);
        check("bridge_e2", 32'(BRIDGE_BASE), 32'hE2);
        applyStimulus(1'b1, 8'h00, 8'h00);

        resetDuringWait();
        applyStimulus(1'b1, 8'h00, 8'h00);

        applyStimulus(1'b0, 8'h4A, 8'h20);
        applyStimulus(1'b0, 8'h48, 8'hE9);
`ifdef AUTOCONFIG_PRO_EN
        applyStimulus(1'b0, 8'h4C, 8'h00);
        applyStimulus(1'b1, 8'h08, 8'h00);
        applyStimulus(1'b0, 8'h44, 8'h40);
        check("board_en_101", 32'(BOARD_EN), 32'b101);
        check("pro_base_4", 32'(PRO_BASE), 32'h4);
`else
        applyStimulus(1'b0, 8'h4A, 8'h60);
        applyStimulus(1'b0, 8'h48, 8'hA5);
        check("lide_53", 32'(LIDE_BASE), 32'h53);
        check("pro_base_0", 32'(PRO_BASE), 32'h0);
`endif
        check("configured_set", 32'(CONFIGURED), 32'd1);
        probeEmpty();

        for (int pass = 0; pass < 3; pass++) begin
            resetDut();
            randomChain();
            probeEmpty();
        end

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
        $finish;
    end

endmodule

// File: doc/u409_autoconfig.md
Name: u409_autoconfig

Overview:
Zorro II AUTOCONFIG responder for U409. It serves the nibble-wide configuration ROM for the on-board functions at $00E8xxxx, answers 68040 bus cycles with TAn, and latches the base addresses Kickstart writes. It sits on the other side of the address decoder: it consumes the decoder's AUTOCONFIG_SPACE select and produces BRIDGE_BASE, LIDE_BASE, PRO_BASE and CONFIGURED, which the decoder then uses.

Parameters:
WAIT_STATES, 2, CLK40 cycles between the TSn sample and TAn assertion (range 1-7).
MFG_ID, 16'h0A1C, manufacturer number served at offsets $10-$16.
PROD_BRIDGE, 8'h01, product number for board 0 (bridge registers).
PROD_LIDE, 8'h02, product number for board 1 (ATA/LIDE).
PROD_PRO, 8'h03, product number for board 2 (Prometheus window).

Ports:
CLK40  in  1  system clock
RESETn  in  1  synchronous, active-low reset, sampled on CLK40
TSn  in  1  68040 transfer start, active low
RnW  in  1  1 = read, 0 = write
AUTOCONFIG_SPACE  in  1  decoder select for $00E8xxxx
A  in  7  A[7:1], register offset
D_IN  in  8  D[31:24] write data
D_OUT  out  4  read nibble, driven onto D[31:28]
D_OE  out  1  data output enable
TAn  out  1  transfer acknowledge, active low
BRIDGE_BASE  out  8  A[23:16] base, 64 KB board
LIDE_BASE  out  7  A[23:17] base, 128 KB board
PRO_BASE  out  4  A[31:28] base, 256 MB board
BOARD_EN  out  3  per-board valid: [0] bridge, [1] LIDE, [2] Prometheus
CONFIGURED  out  1  set when the configuration chain is complete

Behaviour:
- Reset (RESETn low at a CLK40 edge) clears everything:
  - TAn=1, D_OE=0, D_OUT=0, all bases=0, BOARD_EN=000, CONFIGURED=0.
  - Board index BIDX=0; state IDLE.
  - Reset wins over any cycle in progress; on the next edge TAn=1 and D_OE=0.
- States:
  - IDLE: TSn=0, AUTOCONFIG_SPACE=1 and BIDX<NBOARDS at the same edge -> WAIT. Latch A, RnW and a wait counter (WC=WAIT_STATES-1).
  - WAIT: decrement WC; at WC=0 -> ACK. For reads, D_OE=1 and D_OUT is valid throughout WAIT.
  - ACK: TAn=0 for exactly one clock. D_OE stays 1 for reads. Writes take effect at this edge. Next state is IDLE with TAn=1 and D_OE=0.
- Latency: TAn goes low WAIT_STATES+1 clocks after the TSn sample. Any TSn seen outside IDLE is ignored.
- Read data for board BIDX, as a logical nibble:
  - $00 = type[7:4], $02 = type[3:0]. Type is $C1 for bridge, $D2 for LIDE (ROM present), $84 for Prometheus (Z3, 256 MB extended size).
  - $04/$06 = product high/low nibbles.
  - $08 = flags[7:4]. Flags are $30 for Prometheus and $00 otherwise.
  - $10/$12/$14/$16 = MFG_ID nibbles, MSB first.
  - All other offsets read logical 0.
  - D_OUT is the logical nibble at $00, $02, $40 and $42, and the inverted nibble at every other offset. So unused offsets read $F.
- Writes:
  - $4A on a Z2 board: hold D_IN[7:4] in a low-nibble latch; no advance.
  - $48 on a Z2 board: set the base. Bridge gets {D_IN[7:4], lowlatch}. LIDE gets {D_IN[7:4], lowlatch[3:1]}. Set BOARD_EN[BIDX]=1 and BIDX++.
  - $44 on a Z3 board: PRO_BASE=D_IN[7:4], BOARD_EN[2]=1, BIDX++.
  - $4C (shut-up) on any board: base unchanged at 0, BOARD_EN bit stays 0, BIDX++.
  - Writes to any other offset are acknowledged and have no effect.
- CONFIGURED=1 on the clock after BIDX reaches NBOARDS, and holds until reset.
- Once BIDX=NBOARDS the block ignores AUTOCONFIG_SPACE cycles: TAn stays 1 and D_OE stays 0, so the access bus-errors by timeout as an empty slot.
- NBOARDS is 3, or 2 when AUTOCONFIG_PRO_EN is undefined.

Optional Feature:
AUTOCONFIG_PRO_EN.
- Defined: board 2 (Prometheus, Z3) is part of the chain, and CONFIGURED sets after the third advance.
- Undefined: there is no Prometheus board. PRO_BASE and BOARD_EN[2] are tied to 0, and CONFIGURED sets after board 1 advances.

Test Plan:
1. Reset, then read $00 and $02 with WAIT_STATES=2 -> TAn low on the 3rd clock after TS for one clock; D_OUT=$C then $1; D_OE high for 3 clocks per read.
2. Read $04, $06 and $10 on board 0 -> D_OUT=$F, $E (inverted $01) and $F (inverted $0 of $0A1C).
3. Write $4A=$20, then $48=$E9, on board 0 -> BRIDGE_BASE=$E2 (high nibble $E from $48, low nibble $2 from $4A), BOARD_EN=001; the next read of $00 returns $D (LIDE).
4. Write $4C to board 1, then $44=$40 to board 2 -> LIDE_BASE=0, BOARD_EN=101, PRO_BASE=4, CONFIGURED=1 one clock later; a further $E80000 read gets no TAn.
5. Assert RESETn low during WAIT of a read -> TAn stays 1, D_OE=0 the next clock, all outputs at reset values, BIDX=0.
6. AUTOCONFIG_PRO_EN undefined: configure boards 0 and 1 -> CONFIGURED=1 after the board 1 $48 write, PRO_BASE=0.
